// File: rtl/systolic_sched_pkg.sv
// Shared types and sizing helpers for the systolic MAC sequencer.
// Optional perf counter: SYSTOLIC_SCHED_PERF_EN.
package systolic_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DONE
  } state_t;

  localparam int DEF_SIZE   = 16;
  localparam int DEF_KDEPTH = 16;
  localparam int KLEN_W     = $clog2(DEF_KDEPTH) + 1;
  localparam int CNT_W      = KLEN_W;
  localparam int T_W        = $clog2(DEF_KDEPTH + 2 * DEF_SIZE);

  function automatic int compute_len(input int k, input int size);
    return k + 2 * size - 2;
  endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// Diagonal read-enable skew for one operand's FIFO bank.
// Reads aimed at empty FIFOs are dropped and flagged.
module systolic_skew_gen
  import systolic_sched_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int KW   = KLEN_W,
  parameter int TW   = T_W
) (
  input  logic [TW-1:0]   t,
  input  logic [KW-1:0]   k,
  input  logic            active,
  input  logic [SIZE-1:0] empty,
  output logic [SIZE-1:0] ren,
  output logic            hit
);

  logic [SIZE-1:0] sched;

  always_comb begin
    sched = '0;
    for (int i = 0; i < SIZE; i++) begin
      sched[i] = active
        && (int'(t) >= i)
        && (int'(t) < i + int'(k));
    end
    ren = sched & ~empty;
    hit = |(sched & empty);
  end

endmodule

// File: rtl/systolic_sched.sv
// Load/compute sequencer for the systolic MAC array.
// Define SYSTOLIC_SCHED_PERF_EN to add the perf_cycles counter.
module systolic_sched
  import systolic_sched_pkg::*;
#(
  parameter int SIZE   = DEF_SIZE,
  parameter int KDEPTH = DEF_KDEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [$clog2(KDEPTH):0] k_len,
  input  logic                    x_send_val,
  output logic                    x_send_rdy,
  input  logic                    w_send_val,
  output logic                    w_send_rdy,
  output logic [SIZE-1:0]         x_fifo_wen,
  output logic [SIZE-1:0]         x_fifo_ren,
  input  logic [SIZE-1:0]         x_fifo_full,
  input  logic [SIZE-1:0]         x_fifo_empty,
  output logic [SIZE-1:0]         w_fifo_wen,
  output logic [SIZE-1:0]         w_fifo_ren,
  input  logic [SIZE-1:0]         w_fifo_full,
  input  logic [SIZE-1:0]         w_fifo_empty,
  output logic                    mac_en,
  output logic                    acc_clr,
  output logic                    busy,
  output logic                    done,
  output logic                    underflow
`ifdef SYSTOLIC_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);

  localparam int KW = $clog2(KDEPTH) + 1;
  localparam int TW = $clog2(KDEPTH + 2 * SIZE);

  state_t        state, state_n;
  logic [KW-1:0] k_q, x_cnt, w_cnt;
  logic [TW-1:0] t, t_last;
  logic          go, x_fire, w_fire;
  logic          x_hit, w_hit, uf_q;

  assign go         = (state == IDLE) && start && (k_len != '0);
  assign x_send_rdy = (state == LOAD) && (x_cnt < k_q) && ~|x_fifo_full;
  assign w_send_rdy = (state == LOAD) && (w_cnt < k_q) && ~|w_fifo_full;
  assign x_fire     = x_send_val && x_send_rdy;
  assign w_fire     = w_send_val && w_send_rdy;
  assign x_fifo_wen = {SIZE{x_fire}};
  assign w_fifo_wen = {SIZE{w_fire}};
  assign t_last     = TW'(compute_len(int'(k_q), SIZE) - 1);

  assign mac_en    = (state == COMPUTE);
  assign acc_clr   = go;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign underflow = uf_q;

  systolic_skew_gen #(.SIZE(SIZE), .KW(KW), .TW(TW)) u_x_skew (
    .t      (t),
    .k      (k_q),
    .active (mac_en),
    .empty  (x_fifo_empty),
    .ren    (x_fifo_ren),
    .hit    (x_hit)
  );

  systolic_skew_gen #(.SIZE(SIZE), .KW(KW), .TW(TW)) u_w_skew (
    .t      (t),
    .k      (k_q),
    .active (mac_en),
    .empty  (w_fifo_empty),
    .ren    (w_fifo_ren),
    .hit    (w_hit)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (go) state_n = LOAD;
      LOAD:    if (x_cnt == k_q && w_cnt == k_q) state_n = COMPUTE;
      COMPUTE: if (t == t_last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      k_q   <= '0;
      x_cnt <= '0;
      w_cnt <= '0;
      t     <= '0;
      uf_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (go) begin
        k_q   <= k_len;
        x_cnt <= '0;
        w_cnt <= '0;
      end else begin
        if (x_fire) x_cnt <= x_cnt + 1'b1;
        if (w_fire) w_cnt <= w_cnt + 1'b1;
      end
      t <= (state == COMPUTE) ? t + 1'b1 : '0;
      if (go) uf_q <= 1'b0;
      else if (x_hit || w_hit) uf_q <= 1'b1;
    end
  end

`ifdef SYSTOLIC_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_cycles <= '0;
    else if (go) perf_cycles <= '0;
    else if (busy && ~&perf_cycles) perf_cycles <= perf_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_systolic_sched.sv
// Directed bench for systolic_sched at SIZE=4, KDEPTH=8.
// Perf checks compile in with SYSTOLIC_SCHED_PERF_EN.
module tb_systolic_sched;

  localparam int SIZE = 4;
  localparam int KDEPTH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [3:0]      k_len;
  logic            x_send_val, x_send_rdy;
  logic            w_send_val, w_send_rdy;
  logic [SIZE-1:0] x_fifo_wen, x_fifo_ren, x_fifo_full, x_fifo_empty;
  logic [SIZE-1:0] w_fifo_wen, w_fifo_ren, w_fifo_full, w_fifo_empty;
  logic            mac_en, acc_clr, busy, done, underflow;
`ifdef SYSTOLIC_SCHED_PERF_EN
  logic [31:0]     perf_cycles;
`endif

  int total = 0;
  int bad = 0;
  int xacc = 0;
  int wacc = 0;
  int wen_bad = 0;

  always #5 clk = ~clk;

  systolic_sched #(.SIZE(SIZE), .KDEPTH(KDEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .k_len        (k_len),
    .x_send_val   (x_send_val),
    .x_send_rdy   (x_send_rdy),
    .w_send_val   (w_send_val),
    .w_send_rdy   (w_send_rdy),
    .x_fifo_wen   (x_fifo_wen),
    .x_fifo_ren   (x_fifo_ren),
    .x_fifo_full  (x_fifo_full),
    .x_fifo_empty (x_fifo_empty),
    .w_fifo_wen   (w_fifo_wen),
    .w_fifo_ren   (w_fifo_ren),
    .w_fifo_full  (w_fifo_full),
    .w_fifo_empty (w_fifo_empty),
    .mac_en       (mac_en),
    .acc_clr      (acc_clr),
    .busy         (busy),
    .done         (done),
    .underflow    (underflow)
`ifdef SYSTOLIC_SCHED_PERF_EN
    ,
    .perf_cycles  (perf_cycles)
`endif
  );

  always @(posedge clk) begin
    xacc <= xacc + int'(x_send_val && x_send_rdy);
    wacc <= wacc + int'(w_send_val && w_send_rdy);
    wen_bad <= wen_bad
      + int'(x_fifo_wen != ((x_send_val && x_send_rdy) ? 4'hF : 4'h0))
      + int'(w_fifo_wen != ((w_send_val && w_send_rdy) ? 4'hF : 4'h0));
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mac(input int lim, output int n);
    n = 0;
    while (!mac_en && n < lim) begin
      tick();
      #1;
      n++;
    end
    check("mac_start", 32'(mac_en), 1);
  endtask

  task automatic run_compute(input int k, input logic [3:0] ex);
    int len;
    logic [3:0] s;
    len = k + 2 * SIZE - 2;
    for (int t = 0; t < len; t++) begin
      s = '0;
      for (int i = 0; i < SIZE; i++)
        s[i] = (t >= i) && (t < i + k);
      check("mac_en", 32'(mac_en), 1);
      check("x_ren", 32'(x_fifo_ren), 32'(s & ~ex));
      check("w_ren", 32'(w_fifo_ren), 32'(s));
      tick();
      #1;
    end
    check("done", 32'(done), 1);
    check("done_mac", 32'(mac_en), 0);
    check("done_busy", 32'(busy), 1);
  endtask

  task automatic end_op();
    tick();
    #1;
    check("post_done", 32'(done), 0);
    check("post_busy", 32'(busy), 0);
  endtask

  task automatic go(input logic [3:0] k);
    tick();
    start = 1'b1;
    k_len = k;
    #1;
    check("acc_clr", 32'(acc_clr), 1);
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n, xb, wb;
    rst = 1'b0;
    start = 1'b0;
    k_len = '0;
    x_send_val = 1'b0;
    w_send_val = 1'b0;
    x_fifo_full = '0;
    x_fifo_empty = '0;
    w_fifo_full = '0;
    w_fifo_empty = '0;
    repeat (2) tick();
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_mac", 32'(mac_en), 0);
    check("rst_uf", 32'(underflow), 0);
    check("rst_rdy", 32'({x_send_rdy, w_send_rdy}), 0);
    check("rst_vec", 32'({x_fifo_wen, x_fifo_ren, w_fifo_wen, w_fifo_ren}), 0);
    tick();
    rst = 1'b1;

    // reset in the middle of LOAD
    go(3);
    x_send_val = 1'b1;
    #1;
    check("a_busy", 32'(busy), 1);
    check("a_wen", 32'(x_fifo_wen), 4'hF);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("a_rst_busy", 32'(busy), 0);
    check("a_rst_rdy", 32'(x_send_rdy), 0);
    check("a_rst_wen", 32'(x_fifo_wen), 0);
    tick();
    rst = 1'b1;
    x_send_val = 1'b0;

    // K=3 back to back
    go(3);
    xb = xacc;
    wb = wacc;
    x_send_val = 1'b1;
    w_send_val = 1'b1;
    #1;
    wait_mac(20, n);
    x_send_val = 1'b0;
    w_send_val = 1'b0;
    #1;
    check("b_load_cyc", 32'(n), 4);
    check("b_xacc", 32'(xacc - xb), 3);
    check("b_wacc", 32'(wacc - wb), 3);
    run_compute(3, 4'h0);
    end_op();

    // K=2 with late w
    go(2);
    x_send_val = 1'b1;
    #1;
    tick();
    #1;
    tick();
    #1;
    check("c_xrdy_lo", 32'(x_send_rdy), 0);
    repeat (5) begin
      tick();
      #1;
      check("c_wait_mac", 32'(mac_en), 0);
    end
    w_send_val = 1'b1;
    #1;
    check("c_wrdy", 32'(w_send_rdy), 1);
    tick();
    #1;
    tick();
    #1;
    check("c_load_mac", 32'(mac_en), 0);
    check("c_wrdy_lo", 32'(w_send_rdy), 0);
    tick();
    #1;
    check("c_comp", 32'(mac_en), 1);
    x_send_val = 1'b0;
    w_send_val = 1'b0;
    #1;
    run_compute(2, 4'h0);
    end_op();

    // x FIFO full stall
    go(1);
    x_fifo_full = 4'b0010;
    x_send_val = 1'b1;
    w_send_val = 1'b1;
    #1;
    check("d_xrdy", 32'(x_send_rdy), 0);
    check("d_xwen", 32'(x_fifo_wen), 0);
    check("d_wrdy", 32'(w_send_rdy), 1);
    tick();
    #1;
    check("d_xrdy2", 32'(x_send_rdy), 0);
    check("d_xwen2", 32'(x_fifo_wen), 0);
    tick();
    x_fifo_full = '0;
    #1;
    check("d_xrdy3", 32'(x_send_rdy), 1);
    check("d_xwen3", 32'(x_fifo_wen), 4'hF);
    tick();
    x_send_val = 1'b0;
    w_send_val = 1'b0;
    #1;
    wait_mac(5, n);
    check("d_load_cyc", 32'(n), 1);
    run_compute(1, 4'h0);
    end_op();

    // ignored starts
    tick();
    start = 1'b1;
    k_len = 4'd0;
    #1;
    check("e_k0_clr", 32'(acc_clr), 0);
    tick();
    start = 1'b0;
    #1;
    check("e_k0_busy", 32'(busy), 0);
    go(2);
    x_send_val = 1'b1;
    w_send_val = 1'b1;
    #1;
    wait_mac(20, n);
    x_send_val = 1'b0;
    w_send_val = 1'b0;
    start = 1'b1;
    k_len = 4'd5;
    #1;
    check("e_busy_clr", 32'(acc_clr), 0);
    start = 1'b0;
    #1;
    run_compute(2, 4'h0);
    end_op();

    // underflow on row 2
    go(4);
    x_send_val = 1'b1;
    w_send_val = 1'b1;
    #1;
    wait_mac(20, n);
    check("f_load_cyc", 32'(n), 5);
    x_send_val = 1'b0;
    w_send_val = 1'b0;
    x_fifo_empty = 4'b0100;
    #1;
    run_compute(4, 4'b0100);
    check("f_uf", 32'(underflow), 1);
`ifdef SYSTOLIC_SCHED_PERF_EN
    check("f_perf", perf_cycles, 15);
`endif
    x_fifo_empty = '0;
    end_op();
    check("f_uf_idle", 32'(underflow), 1);
    tick();
    start = 1'b1;
    k_len = 4'd1;
    #1;
    check("f_uf_start", 32'(underflow), 1);
    tick();
    start = 1'b0;
    #1;
    check("f_uf_clr", 32'(underflow), 0);
    check("wen_consistent", 32'(wen_bad), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_sched.md
Name: systolic_sched

Overview:
Sequencer for the systolic MAC datapath. It accepts deserialized x column-vectors and w row-vectors through val/rdy handshakes and writes them into the per-row x FIFOs and per-column w FIFOs. It then drains the FIFOs with the diagonal skew a systolic array needs, holds mac_en through the pipeline flush, and pulses done. It sits between the two deserializers and the datapath, replacing ad-hoc enable wiring.

Parameters:
SIZE, 16, array dimension (rows = columns = FIFO count per operand)
KDEPTH, 16, maximum vectors per operation; equals per-FIFO depth

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
start  input  1  begin operation; sampled only in IDLE
k_len  input  $clog2(KDEPTH)+1  vectors per operand, K, legal range 1..KDEPTH; latched on start
x_send_val  input  1  x deserializer has a vector
x_send_rdy  output  1  scheduler accepts x vector
w_send_val  input  1  w deserializer has a vector
w_send_rdy  output  1  scheduler accepts w vector
x_fifo_wen  output  SIZE  per-row x FIFO write enable
x_fifo_ren  output  SIZE  per-row x FIFO read enable
x_fifo_full  input  SIZE  per-row x FIFO full
x_fifo_empty  input  SIZE  per-row x FIFO empty
w_fifo_wen  output  SIZE  per-column w FIFO write enable
w_fifo_ren  output  SIZE  per-column w FIFO read enable
w_fifo_full  input  SIZE  per-column w FIFO full
w_fifo_empty  input  SIZE  per-column w FIFO empty
mac_en  output  1  PE accumulate/shift enable
acc_clr  output  1  one-cycle PE accumulator clear
busy  output  1  high outside IDLE
done  output  1  one-cycle completion pulse
underflow  output  1  sticky; a scheduled read found an empty FIFO

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE, all counters clear, and every output is 0.
- FSM states: IDLE, LOAD, COMPUTE, DONE.
- IDLE:
  - start=1 with k_len!=0: latch K, assert acc_clr for that cycle, go to LOAD.
  - start with k_len==0: ignored.
  - start while not IDLE: ignored.
- LOAD:
  - x_send_rdy = (x_cnt<K) && no bit of x_fifo_full set.
  - On x_send_val && x_send_rdy: x_fifo_wen = all ones for that same cycle (combinational), and x_cnt increments.
  - w side is identical and independent. Both sides may fire in the same cycle.
  - When x_cnt==K and w_cnt==K (registered counts), go to COMPUTE next cycle, with step t=0.
- COMPUTE:
  - mac_en=1 every cycle. t increments every cycle.
  - x_fifo_ren[i] = (i <= t < i+K); w_fifo_ren[j] = (j <= t < j+K). This is a diagonal skew of one cycle per row/column.
  - Leave COMPUTE after t = K+2*SIZE-3, i.e. K+2*SIZE-2 cycles total; the last operands reach PE(SIZE-1,SIZE-1) at that point.
  - Then go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. busy is 0 in the IDLE cycle after done.
- Underflow:
  - A scheduled ren to an empty FIFO is suppressed (that ren bit is forced 0) and sets underflow.
  - underflow clears only on reset or on the next accepted start.
- Counter widths: x_cnt/w_cnt are $clog2(KDEPTH)+1 bits; t is $clog2(KDEPTH+2*SIZE) bits. No wrap-around is possible within legal K.
- Reset mid-operation: abandons the operation immediately. FIFO contents are the owner's responsibility.

Optional Feature:
- Macro: SYSTOLIC_SCHED_PERF_EN.
- Defined: adds output perf_cycles, 32 bits. It clears on accepted start, increments every cycle while busy (including LOAD stalls), saturates at all ones, and holds its value in IDLE.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package systolic_sched_pkg holds:
  - the state enum (IDLE/LOAD/COMPUTE/DONE);
  - width localparams for k_len, cnt, and t;
  - a function compute_len(K, SIZE) = K+2*SIZE-2.
- One sub-module, systolic_skew_gen: combinational. Inputs t, K, active, and empty vector; outputs the ren vector and an underflow hit. It is instantiated twice (x and w).

Test Plan (bench uses SIZE=4, KDEPTH=8):
- Reset mid-LOAD after 2 x-vectors -> all outputs 0 immediately; busy=0; a fresh start then loads from x_cnt=0.
- K=3, x and w valid back-to-back -> 3 wen pulses per side in 3 cycles; COMPUTE lasts 9 cycles; x_fifo_ren[0] high at t=0..2, x_fifo_ren[3] high at t=3..5; done is a single pulse 1 cycle after the last mac_en.
- K=2, w_send_val delayed 5 cycles after x finishes -> x_send_rdy low after 2 accepts; COMPUTE entered only after the 2nd w accept.
- x_fifo_full[1]=1 during LOAD -> x_send_rdy=0 and no x_fifo_wen until full drops.
- start with k_len=0, and start during COMPUTE -> both ignored; state and counters unchanged.
- K=4, x_fifo_empty[2] forced high in COMPUTE -> x_fifo_ren[2] stays 0 and underflow=1 until the next start. With SYSTOLIC_SCHED_PERF_EN and no stalls, perf_cycles=4+10+1=15 at done.
